// File: rtl/apollo_seq_pkg.sv
// Shared definitions for the PC fetch/execute sequencer.
// State encoding and default widths/vector used by the top and the bench.
package apollo_seq_pkg;

    localparam int unsigned ADDR_W_DEF     = 12;
    localparam int unsigned WORD_W_DEF     = 15;
    localparam logic [11:0] INT_VECTOR_DEF = 12'h800;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_EXEC      = 3'd2,
        ST_UPDATE    = 3'd3,
        ST_INT_ENTRY = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of PC, instruction-memory, execute-unit and interrupt signals.
// The master modport belongs to the sequencer; slave is its environment.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned WORD_W = 15
);
    logic              run;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_en;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;
    logic              instr_valid;
    logic [WORD_W-1:0] instr;
    logic              exec_done;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_addr;
    logic              irq;
    logic              irq_ack;
    logic              int_resume;
    logic [ADDR_W-1:0] saved_pc;
    logic              halted;
    logic              fault;

    modport master (
        input  run, pc_addr, mem_ack, mem_rdata, exec_done, branch_taken,
               branch_addr, irq, int_resume,
        output pc_en, pc_load, pc_load_addr, mem_req, mem_addr, instr_valid,
               instr, irq_ack, saved_pc, halted, fault
    );

    modport slave (
        output run, pc_addr, mem_ack, mem_rdata, exec_done, branch_taken,
               branch_addr, irq, int_resume,
        input  pc_en, pc_load, pc_load_addr, mem_req, mem_addr, instr_valid,
               instr, irq_ack, saved_pc, halted, fault
    );

endinterface

// File: rtl/seq_timeout_counter.sv
// Down-counter that expires on the LIMIT-th consecutive enabled cycle.
// Reloaded whenever clear_i is high.
module seq_timeout_counter #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned      CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the PC block's increment/load controls.
// One PC update per instruction; interrupts taken only at instruction boundaries.
//
//   state     | meaning
//   IDLE      | halted, waiting for run
//   FETCH     | mem_req at pc_addr, timeout running
//   EXEC      | instruction presented, waiting for exec_done
//   UPDATE    | one-cycle pc_en or branch pc_load
//   INT_ENTRY | save return PC, load interrupt vector
//   FAULT     | fetch timed out, held until reset
module pc_sequencer
    import apollo_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W        = ADDR_W_DEF,
    parameter int unsigned       WORD_W        = WORD_W_DEF,
    parameter int unsigned       FETCH_TIMEOUT = 15,
    parameter logic [ADDR_W-1:0] INT_VECTOR    = ADDR_W'(INT_VECTOR_DEF)
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);
    state_t            state_q, state_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic              br_taken_q, br_taken_d;
    logic [ADDR_W-1:0] br_addr_q, br_addr_d;
    logic [ADDR_W-1:0] saved_pc_q, saved_pc_d;
    logic              int_en_q, int_en_d;
    logic              fetch_expire;

    logic              pc_en, pc_load, mem_req, instr_valid, irq_ack;
    logic [ADDR_W-1:0] pc_load_addr;

    seq_timeout_counter #(.LIMIT(FETCH_TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_q != ST_FETCH),
        .en_i     (state_q == ST_FETCH),
        .expire_o (fetch_expire)
    );

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        br_taken_d   = br_taken_q;
        br_addr_d    = br_addr_q;
        saved_pc_d   = saved_pc_q;
        int_en_d     = int_en_q | bus.int_resume;
        pc_en        = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        mem_req      = 1'b0;
        instr_valid  = 1'b0;
        irq_ack      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                // An ack on the expiring cycle still completes the fetch.
                if (bus.mem_ack) begin
                    instr_d = bus.mem_rdata;
                    state_d = ST_EXEC;
                end else if (fetch_expire) begin
                    state_d = ST_FAULT;
                end
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                if (bus.exec_done) begin
                    br_taken_d = bus.branch_taken;
                    br_addr_d  = bus.branch_addr;
                    state_d    = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (br_taken_q) begin
                    pc_load      = 1'b1;
                    pc_load_addr = br_addr_q;
                end else begin
                    pc_en = 1'b1;
                end
                if (bus.irq && int_en_q) state_d = ST_INT_ENTRY;
                else if (bus.run)        state_d = ST_FETCH;
                else                     state_d = ST_IDLE;
            end
            ST_INT_ENTRY: begin
                // pc_addr already reflects the UPDATE cycle's increment/load.
                saved_pc_d   = bus.pc_addr;
                pc_load      = 1'b1;
                pc_load_addr = INT_VECTOR;
                irq_ack      = 1'b1;
                int_en_d     = 1'b0;
                state_d      = bus.run ? ST_FETCH : ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            br_taken_q <= 1'b0;
            br_addr_q  <= '0;
            saved_pc_q <= '0;
            int_en_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            br_taken_q <= br_taken_d;
            br_addr_q  <= br_addr_d;
            saved_pc_q <= saved_pc_d;
            int_en_q   <= int_en_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.pc_load      = pc_load;
    assign bus.pc_load_addr = pc_load_addr;
    assign bus.mem_req      = mem_req;
    assign bus.mem_addr     = mem_req ? bus.pc_addr : '0;
    assign bus.instr_valid  = instr_valid;
    assign bus.instr        = instr_q;
    assign bus.irq_ack      = irq_ack;
    assign bus.saved_pc     = saved_pc_q;
    assign bus.halted       = (state_q == ST_IDLE);
    assign bus.fault        = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized instruction
// streams checked against an instruction-level model of PC and interrupt state.
module tb_pc_sequencer;
    localparam int unsigned AW  = 12;
    localparam int unsigned WW  = 15;
    localparam int unsigned TO  = 15;
    localparam logic [11:0] VEC = 12'h800;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();

    pc_sequencer #(
        .ADDR_W(AW), .WORD_W(WW), .FETCH_TIMEOUT(TO), .INT_VECTOR(VEC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // PC block emulation: the register the sequencer controls.
    logic [AW-1:0] pc_blk;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pc_blk <= '0;
        else if (bus.pc_load) pc_blk <= bus.pc_load_addr;
        else if (bus.pc_en)   pc_blk <= pc_blk + 12'd1;
    end
    assign bus.pc_addr = pc_blk;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [AW-1:0] exp_pc;
    bit            int_en_m;
    bit            idle_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete instruction, with the expected outcome derived from the
    // instruction-level rules: next PC, optional interrupt entry, halt.
    task automatic do_instr(input int ack_dly, input int exec_dly, input bit br,
                            input logic [AW-1:0] baddr, input bit irq_v,
                            input bit resume, input bit resume_at_entry,
                            input bit run_nxt);
        logic [WW-1:0] word;
        bit            take;
        if (idle_m) begin
            chk("halted_idle", 32'(bus.halted), 1);
            bus.run = 1'b1;
            tick();
        end
        bus.run = run_nxt;
        for (int k = 0; k < ack_dly; k++) begin
            chk("fetch_req", 32'(bus.mem_req), 1);
            chk("fetch_addr", 32'(bus.mem_addr), 32'(exp_pc));
            tick();
        end
        chk("fetch_req", 32'(bus.mem_req), 1);
        chk("fetch_addr", 32'(bus.mem_addr), 32'(exp_pc));
        word          = WW'($urandom);
        bus.mem_rdata = word;
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = WW'($urandom);
        chk("exec_valid", 32'(bus.instr_valid), 1);
        chk("exec_instr", 32'(bus.instr), 32'(word));
        chk("exec_noreq", 32'(bus.mem_req), 0);
        bus.int_resume = resume;
        if (resume) int_en_m = 1'b1;
        for (int k = 0; k < exec_dly; k++) begin
            tick();
            bus.int_resume = 1'b0;
            chk("exec_hold_valid", 32'(bus.instr_valid), 1);
            chk("exec_hold_instr", 32'(bus.instr), 32'(word));
        end
        bus.exec_done    = 1'b1;
        bus.branch_taken = br;
        bus.branch_addr  = baddr;
        bus.irq          = irq_v;
        tick();
        bus.exec_done    = 1'b0;
        bus.int_resume   = 1'b0;
        bus.branch_taken = 1'($urandom);
        bus.branch_addr  = AW'($urandom);
        chk("upd_pc_en", 32'(bus.pc_en), 32'(!br));
        chk("upd_pc_load", 32'(bus.pc_load), 32'(br));
        chk("upd_load_addr", 32'(bus.pc_load_addr), br ? 32'(baddr) : 32'd0);
        chk("upd_no_irq_ack", 32'(bus.irq_ack), 0);
        chk("upd_not_halted", 32'(bus.halted), 0);
        exp_pc = br ? baddr : exp_pc + 12'd1;
        take   = irq_v && int_en_m;
        tick();
        if (take) begin
            chk("int_irq_ack", 32'(bus.irq_ack), 1);
            chk("int_pc_load", 32'(bus.pc_load), 1);
            chk("int_vector", 32'(bus.pc_load_addr), 32'(VEC));
            chk("int_no_pc_en", 32'(bus.pc_en), 0);
            bus.int_resume = resume_at_entry;
            tick();
            bus.int_resume = 1'b0;
            chk("int_saved_pc", 32'(bus.saved_pc), 32'(exp_pc));
            chk("int_ack_pulse", 32'(bus.irq_ack), 0);
            exp_pc   = VEC;
            int_en_m = 1'b0;
        end else begin
            chk("no_irq_ack", 32'(bus.irq_ack), 0);
        end
        idle_m = !run_nxt;
        chk("boundary_halted", 32'(bus.halted), 32'(idle_m));
        chk("boundary_req", 32'(bus.mem_req), 32'(!idle_m));
    endtask

    initial begin
        bus.run          = 1'b0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = '0;
        bus.exec_done    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr  = '0;
        bus.irq          = 1'b0;
        bus.int_resume   = 1'b0;

        #2;
        chk("rst_halted", 32'(bus.halted), 1);
        chk("rst_fault", 32'(bus.fault), 0);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_pc_en", 32'(bus.pc_en), 0);
        chk("rst_pc_load", 32'(bus.pc_load), 0);
        chk("rst_load_addr", 32'(bus.pc_load_addr), 0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 0);
        chk("rst_instr", 32'(bus.instr), 0);
        chk("rst_irq_ack", 32'(bus.irq_ack), 0);
        chk("rst_saved_pc", 32'(bus.saved_pc), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_pc   = '0;
        int_en_m = 1'b1;
        idle_m   = 1'b1;
        tick();

        // Back-to-back minimum-length instructions, PC 0..4.
        for (int i = 0; i < 5; i++) do_instr(0, 0, 0, '0, 0, 0, 0, 1);
        // Interrupt at PC 5, then level irq must not re-enter.
        do_instr(0, 0, 0, '0, 1, 0, 0, 1);
        do_instr(1, 1, 0, '0, 1, 0, 0, 1);
        // Resume re-enables; a resume coincident with entry loses.
        do_instr(0, 0, 0, '0, 1, 1, 1, 1);
        do_instr(0, 0, 0, '0, 1, 0, 0, 1);
        do_instr(0, 2, 0, '0, 0, 1, 0, 1);
        // Branches, including to the top address and the wrap after it.
        do_instr(2, 0, 1, 12'hAAA, 0, 0, 0, 1);
        do_instr(0, 0, 1, 12'hFFF, 0, 0, 0, 1);
        do_instr(0, 0, 0, '0, 0, 0, 0, 1);
        // Ack arriving on the last permitted fetch cycle.
        do_instr(TO - 1, 0, 0, '0, 0, 0, 0, 1);
        // run dropped during fetch; then irq outranking run=0.
        do_instr(4, 0, 0, '0, 0, 0, 0, 0);
        do_instr(0, 0, 0, '0, 1, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            do_instr(($urandom % 3 == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 4)),
                     ($urandom % 4) == 0, AW'($urandom),
                     ($urandom % 3) == 0, ($urandom % 4) == 0,
                     ($urandom % 4) == 0, ($urandom % 5) != 0);
        end

        // Asynchronous reset in the middle of EXEC.
        bus.irq = 1'b0;
        if (idle_m) begin
            bus.run = 1'b1;
            tick();
        end
        bus.mem_rdata = WW'($urandom);
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("pre_rst_valid", 32'(bus.instr_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.instr_valid), 0);
        chk("arst_mem_req", 32'(bus.mem_req), 0);
        chk("arst_pc_en", 32'(bus.pc_en), 0);
        chk("arst_pc_load", 32'(bus.pc_load), 0);
        chk("arst_irq_ack", 32'(bus.irq_ack), 0);
        chk("arst_halted", 32'(bus.halted), 1);
        bus.run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_halted", 32'(bus.halted), 1);

        // Fetch timeout with mem_ack held low.
        bus.run = 1'b1;
        tick();
        for (int k = 0; k < int'(TO); k++) begin
            chk("to_fetch_req", 32'(bus.mem_req), 1);
            chk("to_no_fault", 32'(bus.fault), 0);
            tick();
        end
        chk("to_fault", 32'(bus.fault), 1);
        chk("to_mem_req", 32'(bus.mem_req), 0);
        chk("to_not_halted", 32'(bus.halted), 0);
        for (int k = 0; k < 4; k++) begin
            bus.run     = 1'(k & 1);
            bus.mem_ack = 1'b1;
            tick();
            chk("fault_sticky", 32'(bus.fault), 1);
            chk("fault_no_req", 32'(bus.mem_req), 0);
            chk("fault_no_pc_en", 32'(bus.pc_en), 0);
        end
        bus.mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("fault_cleared", 32'(bus.fault), 0);
        chk("fault_rst_halted", 32'(bus.halted), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
